reg_scoreboard: RTL and testbench

//   Hazard tracker placed in the ID stage, directly upstream of the register file read ports.
//   - Keeps a per-register count of in-flight writes (issued at ID->EXE, retired at WB).
//   - Raises hazard when an instruction in ID reads a register whose value is not yet written back.
//   - hazard drives the IF/ID stall and the ID/EXE bubble.
//   - Covers R0-R14 only; R15 (PC) is never tracked.

---
 rtl/reg_scoreboard_if.sv | 34 +++
 rtl/reg_scoreboard.sv | 109 ++++++++++
 tb/tb_reg_scoreboard.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reg_scoreboard_if                                          |
// | Brief   : ID-stage issue/retire/hazard bundle for reg_scoreboard     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface reg_scoreboard_if;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        src1_en;
    logic        src2_en;
    logic        issue_valid;
    logic        issue_wb_en;
    logic [3:0]  issue_dest;
    logic        writeBackEn;
    logic [3:0]  destWB;
    logic        hazard;
    logic [14:0] pending_mask;
    logic [3:0]  inflight;
    logic        err_underflow;

    modport master (
        output src1, src2, src1_en, src2_en, issue_valid, issue_wb_en,
               issue_dest, writeBackEn, destWB,
        input  hazard, pending_mask, inflight, err_underflow
    );

    modport slave (
        input  src1, src2, src1_en, src2_en, issue_valid, issue_wb_en,
               issue_dest, writeBackEn, destWB,
        output hazard, pending_mask, inflight, err_underflow
    );
endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : reg_scoreboard                                             |
// | Brief   : per-register in-flight write tracker raising RAW hazards   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module reg_scoreboard #(
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave sb
);
    localparam int               c_NREG    = 15;
    localparam int               c_SUM_W   = CNT_W + 4;
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]   r_count [c_NREG];
    logic [CNT_W-1:0]   w_cnt   [16];
    logic [CNT_W-1:0]   w_next  [c_NREG];
    logic [c_NREG-1:0]  w_pend_next;
    logic [c_NREG-1:0]  r_pending;
    logic [3:0]         w_infl_next;
    logic [3:0]         r_inflight;
    logic               w_err_next;
    logic               r_err;
    logic               w_busy1;
    logic               w_busy2;
    logic               w_sat;
    logic               w_hazard;
    logic               w_accept;
    logic [c_SUM_W-1:0] w_sum;

    // A register retiring this cycle is readable because the RF writes on negedge.
    function automatic logic f_busy(input logic [3:0] r, input logic [CNT_W-1:0] cnt,
                                    input logic wb_en, input logic [3:0] wb_dst);
        logic bypass;
        bypass = WB_BYPASS && (cnt == c_CNT_ONE) && wb_en && (wb_dst == r);
        return (r != 4'd15) && (cnt != '0) && !bypass;
    endfunction

    // R15 view reads as permanently idle so it never stalls or saturates.
    always_comb begin
        for (int i = 0; i < c_NREG; i++) begin
            w_cnt[i] = r_count[i];
        end
        w_cnt[15] = '0;
    end

    always_comb begin
        w_busy1  = sb.src1_en && f_busy(sb.src1, w_cnt[sb.src1], sb.writeBackEn, sb.destWB);
        w_busy2  = sb.src2_en && f_busy(sb.src2, w_cnt[sb.src2], sb.writeBackEn, sb.destWB);
        w_sat    = sb.issue_wb_en && (sb.issue_dest != 4'd15)
                 && (w_cnt[sb.issue_dest] == c_CNT_MAX)
                 && !(sb.writeBackEn && (sb.destWB == sb.issue_dest));
        w_hazard = w_busy1 || w_busy2 || w_sat;
        w_accept = sb.issue_valid && !w_hazard;
    end

    generate
        for (genvar i = 0; i < c_NREG; i++) begin : g_reg
            logic w_inc;
            logic w_dec;

            assign w_inc          = w_accept && sb.issue_wb_en && (sb.issue_dest == 4'(i));
            assign w_dec          = sb.writeBackEn && (sb.destWB == 4'(i)) && (r_count[i] != '0);
            assign w_next[i]      = r_count[i] + CNT_W'(w_inc) - CNT_W'(w_dec);
            assign w_pend_next[i] = (w_next[i] != '0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_count[i] <= '0;
                end else begin
                    r_count[i] <= w_next[i];
                end
            end
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_NREG; i++) begin
            w_sum = w_sum + c_SUM_W'(w_next[i]);
        end
        w_infl_next = (w_sum > c_SUM_W'(15)) ? 4'd15 : w_sum[3:0];
        w_err_next  = r_err || (sb.writeBackEn && (sb.destWB != 4'd15)
                               && (w_cnt[sb.destWB] == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            r_pending  <= w_pend_next;
            r_inflight <= w_infl_next;
            r_err      <= w_err_next;
        end
    end

    assign sb.hazard        = w_hazard;
    assign sb.pending_mask  = r_pending;
    assign sb.inflight      = r_inflight;
    assign sb.err_underflow = r_err;
endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_reg_scoreboard                                          |
// | Brief   : reference-model scoreboard bench for reg_scoreboard        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_reg_scoreboard;
    localparam int c_CMAX = 3;

    typedef struct packed {
        logic        hz;
        logic [14:0] mask;
        logic [3:0]  infl;
        logic        err;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    obs_t q[$];
    int   m_cnt[15];
    logic m_err = 1'b0;

    reg_scoreboard_if sb();

    reg_scoreboard #(.CNT_W(2), .WB_BYPASS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb.slave)
    );

    always #5 clk = ~clk;

    function automatic logic m_busy(input logic [3:0] r, input logic we, input logic [3:0] dw);
        if (r == 4'd15) return 1'b0;
        if (m_cnt[r] == 0) return 1'b0;
        if (m_cnt[r] == 1 && we && dw == r) return 1'b0;
        return 1'b1;
    endfunction

    // Drives one cycle, advances the model, and returns observed and expected outputs.
    task automatic cyc(input logic r, input logic [3:0] s1, input logic e1,
                       input logic [3:0] s2, input logic e2, input logic iv,
                       input logic iwe, input logic [3:0] id, input logic we,
                       input logic [3:0] dw, output obs_t o, output obs_t e);
        obs_t x;
        logic acc;
        int   sum;
        rst = r;
        sb.src1 = s1; sb.src1_en = e1; sb.src2 = s2; sb.src2_en = e2;
        sb.issue_valid = iv; sb.issue_wb_en = iwe; sb.issue_dest = id;
        sb.writeBackEn = we; sb.destWB = dw;
        x.hz = (e1 && m_busy(s1, we, dw)) || (e2 && m_busy(s2, we, dw))
             || (iwe && id != 4'd15 && m_cnt[id] == c_CMAX && !(we && dw == id));
        if (r) begin
            for (int i = 0; i < 15; i++) m_cnt[i] = 0;
            m_err = 1'b0;
        end else begin
            acc = iv && !x.hz;
            if (we && dw != 4'd15) begin
                if (m_cnt[dw] == 0) m_err = 1'b1;
                else m_cnt[dw] = m_cnt[dw] - 1;
            end
            if (acc && iwe && id != 4'd15) m_cnt[id] = m_cnt[id] + 1;
        end
        sum = 0;
        for (int i = 0; i < 15; i++) begin
            x.mask[i] = (m_cnt[i] != 0);
            sum += m_cnt[i];
        end
        x.infl = (sum > 15) ? 4'd15 : 4'(sum);
        x.err  = m_err;
        q.push_back(x);
        #2 o.hz = sb.hazard;
        @(posedge clk);
        #1;
        o.mask = sb.pending_mask;
        o.infl = sb.inflight;
        o.err  = sb.err_underflow;
        e = q.pop_front();
    endtask

    task automatic idle(output obs_t o, output obs_t e);
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, o, e);
    endtask

    task automatic issue(input logic [3:0] id, output obs_t o, output obs_t e);
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, id, 1'b0, 4'd0, o, e);
    endtask

    task automatic retire(input logic [3:0] dw, output obs_t o, output obs_t e);
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, dw, o, e);
    endtask

    task automatic test_reset;
        obs_t o, e;
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), o, e);
            total++;
            if ({o.mask, o.infl, o.err} !== 20'h0) begin
                bad++; $display("FAIL reset_regs: got %h want 00000", {o.mask, o.infl, o.err});
            end
        end
        for (int s = 0; s < 16; s++) begin
            cyc(1'b0, 4'(s), 1'b1, 4'(15 - s), 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, o, e);
            total++;
            if (o.hz !== 1'b0) begin
                bad++; $display("FAIL reset_hazard src=%0d: got %b want 0", s, o.hz);
            end
        end
    endtask

    task automatic test_raw_bypass;
        obs_t o, e;
        issue(4'd3, o, e);
        total++;
        if (o !== e || o.mask[3] !== 1'b1) begin
            bad++; $display("FAIL raw_issue: got %h want %h", o, e);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, o, e);
            total++;
            if (o.hz !== 1'b1 || o !== e) begin
                bad++; $display("FAIL raw_stall: got %h want %h", o, e);
            end
        end
        cyc(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 4'd3, o, e);
        total++;
        if (o.hz !== 1'b0 || o.mask[3] !== 1'b0 || o !== e) begin
            bad++; $display("FAIL raw_bypass: got %h want %h", o, e);
        end
    endtask

    task automatic test_same_cycle;
        obs_t o, e;
        logic [3:0] infl0;
        issue(4'd5, o, e);
        infl0 = o.infl;
        cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 4'd5, o, e);
        total++;
        if (o.mask[5] !== 1'b1 || o.infl !== infl0 || o !== e) begin
            bad++; $display("FAIL same_cycle: got %h want %h infl0=%0d", o, e, infl0);
        end
        retire(4'd5, o, e);
        total++;
        if (o.mask[5] !== 1'b0 || o !== e) begin
            bad++; $display("FAIL same_cycle_clear: got %h want %h", o, e);
        end
    endtask

    task automatic test_saturate;
        obs_t o, e;
        for (int k = 0; k < 3; k++) begin
            issue(4'd7, o, e);
            total++;
            if (o !== e) begin
                bad++; $display("FAIL sat_fill: got %h want %h", o, e);
            end
        end
        issue(4'd7, o, e);
        total++;
        if (o.hz !== 1'b1 || o.infl !== 4'd3 || o !== e) begin
            bad++; $display("FAIL sat_block: got %h want %h", o, e);
        end
        retire(4'd7, o, e);
        total++;
        if (o.infl !== 4'd2 || o !== e) begin
            bad++; $display("FAIL sat_retire: got %h want %h", o, e);
        end
        issue(4'd7, o, e);
        total++;
        if (o.hz !== 1'b0 || o.infl !== 4'd3 || o !== e) begin
            bad++; $display("FAIL sat_reissue: got %h want %h", o, e);
        end
        for (int k = 0; k < 3; k++) retire(4'd7, o, e);
        total++;
        if (o.mask[7] !== 1'b0 || o !== e) begin
            bad++; $display("FAIL sat_drain: got %h want %h", o, e);
        end
    endtask

    task automatic test_underflow;
        obs_t o, e;
        retire(4'd9, o, e);
        total++;
        if (o.err !== 1'b1 || o !== e) begin
            bad++; $display("FAIL underflow_set: got %h want %h", o, e);
        end
        for (int k = 0; k < 3; k++) begin
            idle(o, e);
            total++;
            if (o.err !== 1'b1 || o !== e) begin
                bad++; $display("FAIL underflow_sticky: got %h want %h", o, e);
            end
        end
        cyc(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, o, e);
        total++;
        if (o.err !== 1'b0 || o !== e) begin
            bad++; $display("FAIL underflow_clear: got %h want %h", o, e);
        end
    endtask

    task automatic test_r15;
        obs_t o, e, p;
        issue(4'd2, p, e);
        cyc(1'b0, 4'd15, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 4'd15, 1'b1, 4'd15, o, e);
        total++;
        if (o.hz !== 1'b0 || o.mask !== p.mask || o.infl !== p.infl || o.err !== 1'b0 || o !== e) begin
            bad++; $display("FAIL r15_ignored: got %h want %h", o, e);
        end
        retire(4'd2, o, e);
        total++;
        if (o !== e) begin
            bad++; $display("FAIL r15_cleanup: got %h want %h", o, e);
        end
    endtask

    task automatic test_inflight_clamp;
        obs_t o, e;
        for (int k = 0; k < 16; k++) begin
            issue(4'(k % 8), o, e);
            total++;
            if (o !== e) begin
                bad++; $display("FAIL clamp_fill: got %h want %h", o, e);
            end
        end
        total++;
        if (o.infl !== 4'd15) begin
            bad++; $display("FAIL clamp_value: got %0d want 15", o.infl);
        end
        for (int k = 0; k < 16; k++) retire(4'(k % 8), o, e);
        total++;
        if (o.infl !== 4'd0 || o.mask !== 15'h0 || o !== e) begin
            bad++; $display("FAIL clamp_drain: got %h want %h", o, e);
        end
    endtask

    task automatic test_back_to_back;
        obs_t o, e;
        for (int k = 0; k < 300; k++) begin
            cyc(1'b0, 4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom_range(0, 15)),
                1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom_range(0, 8)),
                1'($urandom), 4'($urandom_range(0, 8)), o, e);
            total++;
            if (o !== e) begin
                bad++; $display("FAIL random cycle %0d: got %h want %h", k, o, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 15; i++) m_cnt[i] = 0;
        test_reset();
        test_raw_bypass();
        test_same_cycle();
        test_saturate();
        test_underflow();
        test_r15();
        test_inflight_clamp();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
